// File: rtl/risc8_io_arbiter.sv
// risc8_io_arbiter
// Two-master arbiter for the risc8 I/O register space (PORTB/DDRB/PINB etc).
// Master 0 is the CPU I/O bus, master 1 the debug/DMA port. One single-beat
// access at a time: IDLE (arbitrate + latch) -> ACCESS (strobe) -> DONE (ack).
// Round-robin between the masters, with an optional bounded lock. The lock
// lets the previous owner win ties for up to MAX_LOCK grants in a row, so
// that read-modify-write sequences stay atomic.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   mX_req/we/addr/wdata  master X request (level, held until mX_ack)
//   mX_lock               master X wants tie priority on its next access
//   mX_gnt                master X owns the bus (ACCESS or DONE)
//   mX_ack                one-cycle completion pulse
//   mX_rdata              read data, valid with mX_ack and held afterwards
//   io_addr/io_wdata      registered shared address / write data
//   io_we/io_re           one-cycle write / read strobes
//   io_rdata              combinational read data from the register bank
module risc8_io_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [7:0]        m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [7:0]        m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [7:0]        m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [7:0]        m1_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic [7:0]        io_wdata,
  output logic              io_we,
  output logic              io_re,
  input  logic [7:0]        io_rdata
);

  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  // Master inputs gathered into arrays indexed by master number.
  logic [1:0]             req, we_in, lock_in;
  logic [1:0][ADDR_W-1:0] addr_in;
  logic [1:0][7:0]        wdata_in;

  assign req      = {m1_req, m0_req};
  assign we_in    = {m1_we, m0_we};
  assign lock_in  = {m1_lock, m0_lock};
  assign addr_in  = {m1_addr, m0_addr};
  assign wdata_in = {m1_wdata, m0_wdata};

  state_e            state_q;
  logic              owner_q, owner_lock_q, rr_last_q;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [1:0]        gnt_q, ack_q;
  logic [1:0][7:0]   rdata_q;
  logic [ADDR_W-1:0] io_addr_q;
  logic [7:0]        io_wdata_q;
  logic              io_we_q, io_re_q;

  // Winner selection. A lone requester always wins. On a tie the lock rule
  // is tried first; otherwise the master that did not win last time goes.
  logic win, by_lock;
  always_comb begin
    by_lock = 1'b0;
    win     = req[1] & ~req[0];
    if (&req) begin
      if (owner_lock_q && (lock_cnt_q < LOCK_MAX)) begin
        win     = owner_q;
        by_lock = 1'b1;
      end else begin
        win = ~rr_last_q;
      end
    end
  end

  // A lock-rule win always goes to the previous owner, so the count only
  // grows on a lock win and clears on every other grant. The lock rule
  // requires lock_cnt_q < LOCK_MAX, so the count saturates at MAX_LOCK.
  assign lock_cnt_d = by_lock ? lock_cnt_q + LCW'(1) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      owner_lock_q <= 1'b0;
      rr_last_q    <= 1'b1;
      lock_cnt_q   <= '0;
      gnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      io_addr_q    <= '0;
      io_wdata_q   <= '0;
      io_we_q      <= 1'b0;
      io_re_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          owner_q      <= win;
          owner_lock_q <= lock_in[win];
          rr_last_q    <= win;
          lock_cnt_q   <= lock_cnt_d;
          io_addr_q    <= addr_in[win];
          io_wdata_q   <= wdata_in[win];
          io_we_q      <= we_in[win];
          io_re_q      <= ~we_in[win];
          gnt_q        <= win ? 2'b10 : 2'b01;
          state_q      <= ACCESS;
        end
        ACCESS: begin
          // io_re_q is still high this cycle, so io_rdata is valid here.
          if (io_re_q) rdata_q[owner_q] <= io_rdata;
          io_we_q        <= 1'b0;
          io_re_q        <= 1'b0;
          ack_q[owner_q] <= 1'b1;
          state_q        <= DONE;
        end
        DONE: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt   = gnt_q[0];
  assign m1_gnt   = gnt_q[1];
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign io_addr  = io_addr_q;
  assign io_wdata = io_wdata_q;
  assign io_we    = io_we_q;
  assign io_re    = io_re_q;

endmodule

// File: tb/tb_risc8_io_arbiter.sv
// Self-checking bench for risc8_io_arbiter: directed scenarios followed by
// random traffic. Every cycle is compared against a transaction-level
// reference model, and grant order is checked against hand-derived sequences.
module tb_risc8_io_arbiter;
  localparam int ADDR_W   = 6;
  localparam int MAX_LOCK = 4;

  logic clk = 1'b0, reset = 1'b0;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [7:0] m0_wdata = '0, m1_wdata = '0, io_rdata = '0;
  logic m0_gnt, m0_ack, m1_gnt, m1_ack, io_we, io_re;
  logic [7:0] m0_rdata, m1_rdata, io_wdata;
  logic [ADDR_W-1:0] io_addr;

  risc8_io_arbiter #(.ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a granted access occupies the bus for a fixed number
  // of cycles; m_left counts the cycles of that occupancy still to come
  // (2 = strobe cycle, 1 = ack cycle, 0 = bus free).
  int         m_left, m_lcnt;
  bit         m_own, m_olock, m_rr, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rd [2];

  task automatic model_reset();
    m_left = 0; m_lcnt = 0; m_own = 0; m_olock = 0; m_rr = 1; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
  endtask

  // Called just after each rising edge, with the inputs that edge sampled.
  task automatic model_edge();
    bit w, locked;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_left == 2) begin
      if (!m_we) m_rd[m_own] = io_rdata;
      m_left = 1;
    end else if (m_left == 1) begin
      m_left = 0;
    end else if (m0_req || m1_req) begin
      locked = 0;
      if (m0_req && m1_req) begin
        if (m_olock && m_lcnt < MAX_LOCK) begin w = m_own; locked = 1; end
        else w = !m_rr;
      end else begin
        w = m1_req;
      end
      m_lcnt  = locked ? m_lcnt + 1 : 0;
      m_rr    = w;
      m_own   = w;
      m_olock = w ? m1_lock : m0_lock;
      m_we    = w ? m1_we : m0_we;
      m_addr  = w ? m1_addr : m0_addr;
      m_wdata = w ? m1_wdata : m0_wdata;
      m_left  = 2;
    end
  endtask

  int  glog[$];
  bit  p0 = 0, p1 = 0;

  task automatic check_outputs();
    logic [1:0] eg, ea;
    eg = (m_left > 0) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
    ea = (m_left == 1) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
    chk("gnt", {m1_gnt, m0_gnt}, eg);
    chk("ack", {m1_ack, m0_ack}, ea);
    chk("io_we", io_we, (m_left == 2) && m_we);
    chk("io_re", io_re, (m_left == 2) && !m_we);
    chk("io_addr", io_addr, m_addr);
    chk("io_wdata", io_wdata, m_wdata);
    chk("rdata0", m0_rdata, m_rd[0]);
    chk("rdata1", m1_rdata, m_rd[1]);
    chk("gnt_overlap", m0_gnt & m1_gnt, 0);
    chk("strobe_overlap", io_we & io_re, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (m0_gnt && !p0) glog.push_back(0);
    if (m1_gnt && !p1) glog.push_back(1);
    p0 = m0_gnt; p1 = m1_gnt;
  endtask

  task automatic do_reset();
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
    reset = 0; tick(); tick();
    reset = 1;
    glog.delete();
  endtask

  task automatic chk_log(input string tag, input int exp []);
    chk({tag, "_len"}, glog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk(tag, glog[i], exp[i]);
  endtask

  initial begin
    int n;
    model_reset();
    do_reset();
    chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
    chk("rst_io", {io_we, io_re, io_addr, io_wdata}, 0);

    // Single read by m0.
    m0_req = 1; m0_we = 0; m0_addr = 6'h05; io_rdata = 8'hA5;
    tick();
    chk("rd_re", io_re, 1); chk("rd_addr", io_addr, 6'h05); chk("rd_gnt", m0_gnt, 1);
    tick();
    chk("rd_ack", m0_ack, 1); chk("rd_data", m0_rdata, 8'hA5); chk("rd_re_off", io_re, 0);
    chk("rd_m1", {m1_gnt, m1_ack, m1_rdata}, 0);
    m0_req = 0;
    tick(); tick();

    // Single write by m1.
    m1_req = 1; m1_we = 1; m1_addr = 6'h04; m1_wdata = 8'h3C;
    tick();
    chk("wr_we", io_we, 1); chk("wr_addr", io_addr, 6'h04); chk("wr_wdata", io_wdata, 8'h3C);
    tick();
    chk("wr_we_off", io_we, 0); chk("wr_ack", m1_ack, 1); chk("wr_rdata", m1_rdata, 0);
    m1_req = 0;
    tick(); tick();

    // Tie out of reset: strict alternation starting with m0.
    do_reset();
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
    repeat (12) tick();
    chk_log("tie", '{0, 1, 0, 1});

    // Lock bound: 1 round-robin + MAX_LOCK locked grants to m0, then m1.
    do_reset();
    m0_lock = 1; m0_req = 1; m1_req = 1;
    repeat (21) tick();
    chk_log("lock", '{0, 0, 0, 0, 0, 1, 0});

    // Lock saturated, then m0 alone keeps being granted.
    do_reset();
    m0_lock = 1; m0_req = 1; m1_req = 1;
    n = 0;
    while (glog.size() < 5 && n < 40) begin tick(); n++; end
    chk("sat_reach", glog.size(), 5);
    m1_req = 0;
    repeat (12) tick();
    chk_log("lone", '{0, 0, 0, 0, 0, 0, 0, 0, 0});

    // Reset asserted on the strobe cycle aborts the access.
    do_reset();
    m0_req = 1; m0_we = 0; io_rdata = 8'h5A;
    n = 0;
    while (!io_re && n < 10) begin tick(); n++; end
    chk("abort_strobe_seen", io_re, 1);
    reset = 0; m0_req = 0;
    tick();
    chk("abort_out", {m0_gnt, m1_gnt, m0_ack, m1_ack, io_we, io_re, m0_rdata, m1_rdata}, 0);
    chk("abort_io", {io_addr, io_wdata}, 0);
    tick();
    chk("abort_noack", m0_ack, 0);
    reset = 1; glog.delete();
    m0_req = 1; m1_req = 1;
    tick();
    chk_log("post_abort", '{0});
    m0_req = 0; m1_req = 0;
    tick(); tick();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      reset    = ($urandom_range(0, 99) != 0);
      m0_req   = ($urandom_range(0, 9) < 7);
      m1_req   = ($urandom_range(0, 9) < 7);
      m0_we    = $urandom_range(0, 1);
      m1_we    = $urandom_range(0, 1);
      m0_lock  = $urandom_range(0, 1);
      m1_lock  = ($urandom_range(0, 3) == 0);
      m0_addr  = ADDR_W'($urandom_range(0, 63));
      m1_addr  = ADDR_W'($urandom_range(0, 63));
      m0_wdata = 8'($urandom_range(0, 255));
      m1_wdata = 8'($urandom_range(0, 255));
      io_rdata = 8'($urandom_range(0, 255));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
